user_mgr_arbiter: RTL
=====================

Name: user_mgr_arbiter

Overview:
- Round-robin OBI manager arbiter that shares the single user-domain manager port toward the Croc crossbar between NumReq user-side manager requesters, for example the streamer plus a future DMA or accelerator.
- Sits in user_domain between the user manager ports and the user manager request/response port pair.
- Tracks outstanding transactions in an in-order ID FIFO so each response returns to the requester that issued it.

Parameters:
- NumReq, 2, number of requesting manager ports (2..8).
- MaxTrans, 2, maximum outstanding granted-but-unanswered transactions (power of two, 1..8).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte-enable width is DataWidth/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_req_i  in  NumReq  per-requester A-channel request.
- req_gnt_o  out  NumReq  per-requester grant.
- req_addr_i  in  NumReq*AddrWidth  packed addresses; requester k at slice k.
- req_we_i  in  NumReq  write enable.
- req_be_i  in  NumReq*DataWidth/8  byte enables.
- req_wdata_i  in  NumReq*DataWidth  write data.
- req_rvalid_o  out  NumReq  per-requester response valid.
- req_rdata_o  out  DataWidth  response data, broadcast to all requesters.
- req_err_o  out  1  response error, broadcast; qualified by req_rvalid_o.
- mgr_req_o  out  1  downstream request.
- mgr_gnt_i  in  1  downstream grant.
- mgr_addr_o  out  AddrWidth  downstream address.
- mgr_we_o  out  1  downstream write enable.
- mgr_be_o  out  DataWidth/8  downstream byte enables.
- mgr_wdata_o  out  DataWidth  downstream write data.
- mgr_rvalid_i  in  1  downstream response valid.
- mgr_rdata_i  in  DataWidth  downstream response data.
- mgr_err_i  in  1  downstream response error.
- outstanding_o  out  $clog2(MaxTrans+1)  current outstanding count.
- unexp_rsp_o  out  1  sticky flag: response received with no outstanding transaction.

Behaviour:
- Reset (rst_i high at a clock edge):
  - ID FIFO emptied; outstanding_o=0.
  - Round-robin pointer=0; lock cleared; unexp_rsp_o=0.
  - While rst_i is high, mgr_req_o, req_gnt_o and req_rvalid_o are forced to 0.
- Reset mid-operation discards in-flight IDs. The downstream side is reset by the same signal, so late responses are not expected.
- A-channel path is combinational, zero-cycle: the selected requester's addr/we/be/wdata drive the mgr_* outputs.
  - mgr_req_o = selected req_req_i AND NOT fifo_full.
  - req_gnt_o[sel] = mgr_gnt_i AND mgr_req_o; all other grant bits are 0.
- Arbitration:
  - Round-robin starting at the pointer; the lowest index at or after the pointer with req_req_i high wins.
  - On a handshake (mgr_req_o & mgr_gnt_i) the pointer moves to sel+1 mod NumReq.
- Lock:
  - If mgr_req_o is high and mgr_gnt_i is low, sel is registered and held next cycle regardless of other requests.
  - This preserves OBI stability: A-channel signals do not change until granted.
  - The lock is released on the handshake.
- FIFO full:
  - When outstanding == MaxTrans, mgr_req_o is held at 0. No lock is taken because no request was presented.
  - Push is blocked when full even if a pop occurs in the same cycle; one bubble cycle is accepted.
- ID FIFO:
  - Push sel on a handshake; pop on mgr_rvalid_i.
  - Simultaneous push and pop with the FIFO not full: count unchanged, pointers both advance.
  - Pointers wrap modulo MaxTrans.
- R-channel path is combinational:
  - req_rvalid_o[head] = mgr_rvalid_i when the FIFO is non-empty.
  - rdata and err pass through directly.
  - A response in the same cycle as its own grant is illegal under OBI and need not be handled.
- mgr_rvalid_i with the FIFO empty: response dropped (no req_rvalid_o), unexp_rsp_o set to 1 until reset, count stays 0.
- No combinational path from mgr_gnt_i to mgr_req_o.
- Single requester active: grants every cycle the target grants, with no arbitration bubble.

Test Plan:
- Reset then idle: all req_req_i=0 -> mgr_req_o=0, req_gnt_o=0, outstanding_o=0, unexp_rsp_o=0.
- Requesters 0 and 1 request continuously, target grants every cycle with 1-cycle responses -> grants alternate 0,1,0,1. Responses return in order: rdata 0xA0 to req 0, 0xB1 to req 1.
- Requester 0 issues addr 0x2000_0000 with mgr_gnt_i low for 3 cycles while requester 1 asserts -> mgr_addr_o stays 0x2000_0000 throughout, no switch. Grant goes to 0, then 1 is served next.
- MaxTrans=2, target grants but withholds rvalid -> after 2 handshakes mgr_req_o=0 and outstanding_o=2. One rvalid -> count 1, the next request is presented one cycle later.
- mgr_rvalid_i pulsed with no outstanding transaction -> no req_rvalid_o, unexp_rsp_o=1 and it stays 1 until rst_i.
- rst_i asserted with 2 outstanding -> next cycle outstanding_o=0, pointer 0, and requester 0 wins a 0/1 tie.

Source files
------------

// File: rtl/user_mgr_arbiter.sv
// Round-robin OBI manager arbiter: shares one user-domain manager port between
// NumReq requesters and routes in-order responses back using a small ID FIFO.
module user_mgr_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned MaxTrans  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned BeWidth  = DataWidth / 8,
  localparam int unsigned CntW     = $clog2(MaxTrans + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_req_i,
  output logic [NumReq-1:0]              req_gnt_o,
  input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0]              req_we_i,
  input  logic [NumReq*BeWidth-1:0]      req_be_i,
  input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
  output logic [NumReq-1:0]              req_rvalid_o,
  output logic [DataWidth-1:0]           req_rdata_o,
  output logic                           req_err_o,
  output logic                           mgr_req_o,
  input  logic                           mgr_gnt_i,
  output logic [AddrWidth-1:0]           mgr_addr_o,
  output logic                           mgr_we_o,
  output logic [BeWidth-1:0]             mgr_be_o,
  output logic [DataWidth-1:0]           mgr_wdata_o,
  input  logic                           mgr_rvalid_i,
  input  logic [DataWidth-1:0]           mgr_rdata_i,
  input  logic                           mgr_err_i,
  output logic [CntW-1:0]                outstanding_o,
  output logic                           unexp_rsp_o
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned FifoW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

  logic [IdxW-1:0]  rr_ptr;
  logic [IdxW-1:0]  rr_sel;
  logic [IdxW:0]    cand;
  logic             lock;
  logic [IdxW-1:0]  lock_sel;
  logic [IdxW-1:0]  sel;
  logic             mgr_req;
  logic             handshake;

  logic [IdxW-1:0]  id_fifo [MaxTrans];
  logic [FifoW-1:0] wr_ptr;
  logic [FifoW-1:0] rd_ptr;
  logic [CntW-1:0]  count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [IdxW-1:0]  head_id;
  logic             unexp_q;

  // First requesting index at or after the pointer, wrapping modulo NumReq.
  always_comb begin
    rr_sel = '0;
    cand   = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (req_req_i[cand[IdxW-1:0]]) begin
        rr_sel = cand[IdxW-1:0];
      end
    end
  end

  assign sel        = lock ? lock_sel : rr_sel;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CntW'(MaxTrans));
  assign mgr_req    = req_req_i[sel] & ~fifo_full & ~rst_i;
  assign handshake  = mgr_req & mgr_gnt_i;
  assign push       = handshake;
  assign pop        = mgr_rvalid_i & ~fifo_empty;
  assign head_id    = id_fifo[rd_ptr];

  assign mgr_req_o   = mgr_req;
  assign mgr_addr_o  = req_addr_i[sel*AddrWidth +: AddrWidth];
  assign mgr_we_o    = req_we_i[sel];
  assign mgr_be_o    = req_be_i[sel*BeWidth +: BeWidth];
  assign mgr_wdata_o = req_wdata_i[sel*DataWidth +: DataWidth];

  assign req_rdata_o   = mgr_rdata_i;
  assign req_err_o     = mgr_err_i;
  assign outstanding_o = count;
  assign unexp_rsp_o   = unexp_q;

  always_comb begin
    req_gnt_o    = '0;
    req_rvalid_o = '0;
    if (handshake) begin
      req_gnt_o[sel] = 1'b1;
    end
    if (pop && !rst_i) begin
      req_rvalid_o[head_id] = 1'b1;
    end
  end

  // A stalled request pins the selection so the A-channel stays stable until granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock     <= 1'b0;
      lock_sel <= '0;
      rr_ptr   <= '0;
    end else begin
      lock <= mgr_req & ~mgr_gnt_i;
      if (mgr_req && !mgr_gnt_i) begin
        lock_sel <= sel;
      end
      if (handshake) begin
        rr_ptr <= (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_fifo[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      unexp_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == FifoW'(MaxTrans - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == FifoW'(MaxTrans - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (mgr_rvalid_i && fifo_empty) begin
        unexp_q <= 1'b1;
      end
    end
  end

endmodule
